data_mem_access_unit: RTL and testbench

- Load/store unit that sits directly upstream of port b of the CPU data memory.
- Converts byte/half/word load and store requests from the execute stage into word-only memory transactions.
- Absorbs the memory's two-cycle registered read latency.
- Implements sub-word stores as read-modify-write, because the memory has no byte enables.

---
 rtl/mem_access_pkg.sv | 40 ++++
 rtl/mem_lane_align.sv | 55 +++++
 rtl/data_mem_access_unit.sv | 160 ++++++++++++++++
 tb/tb_data_mem_access_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
// Shared types and constants for the data-memory load/store unit.
//   size_e          : access size encoding carried on req_size (11 is illegal)
//   state_e         : control FSM states of data_mem_access_unit
//   MEM_RD_LATENCY  : registered read latency of data memory port b
//   access_fault()  : illegal-size / misalignment detection for a request
// ---------------------------------------------------------------------------
package mem_access_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } size_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD0,
      ST_RD1,
      ST_RD2,
      ST_WR,
      ST_RESP
   } state_e;

   // RD0 issues the address; data appears MEM_RD_LATENCY edges later, in RD2.
   localparam int MEM_RD_LATENCY = 2;

   // Size 11 is never legal; halves need addr[0]=0, words need addr[1:0]=0.
   function automatic logic access_fault(input logic [1:0] size,
                                         input logic [1:0] offset);
      logic fault;
      fault = 1'b0;
      if (size == 2'b11)                           fault = 1'b1;
      else if (size == SZ_HALF && offset[0])       fault = 1'b1;
      else if (size == SZ_WORD && offset != 2'b00) fault = 1'b1;
      return fault;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane steering for the load/store unit.
// Ports:
//   rd_word     in  word read from memory
//   offset      in  byte offset within the word (addr[1:0])
//   size        in  access size (size_e encoding)
//   is_unsigned in  zero-extend (1) or sign-extend (0) sub-word loads
//   new_data    in  right-aligned store data
//   load_data   out selected lane of rd_word, extended to a full word
//   merged_word out rd_word with the store lane replaced by new_data
// ---------------------------------------------------------------------------
module mem_lane_align
   import mem_access_pkg::*;
#(
   parameter int DATA_WIDTH = 32
)
(
   input  logic [DATA_WIDTH-1:0] rd_word,
   input  logic [1:0]            offset,
   input  logic [1:0]            size,
   input  logic                  is_unsigned,
   input  logic [DATA_WIDTH-1:0] new_data,
   output logic [DATA_WIDTH-1:0] load_data,
   output logic [DATA_WIDTH-1:0] merged_word
);

   logic signed [7:0]  lane_b;
   logic signed [15:0] lane_h;

   // Load path: byte lane chosen by offset[1:0], half lane by offset[1].
   always_comb begin
      lane_b    = rd_word[{offset, 3'b000} +: 8];
      lane_h    = rd_word[{offset[1], 4'b0000} +: 16];
      load_data = rd_word;
      case (size)
         SZ_BYTE: load_data = is_unsigned ? DATA_WIDTH'($unsigned(lane_b))
                                          : DATA_WIDTH'(lane_b);
         SZ_HALF: load_data = is_unsigned ? DATA_WIDTH'($unsigned(lane_h))
                                          : DATA_WIDTH'(lane_h);
         default: load_data = rd_word;
      endcase
   end

   // Store path: overwrite only the addressed lane of the old word.
   always_comb begin
      merged_word = rd_word;
      case (size)
         SZ_BYTE: merged_word[{offset, 3'b000} +: 8]    = new_data[7:0];
         SZ_HALF: merged_word[{offset[1], 4'b0000} +: 16] = new_data[15:0];
         default: merged_word = new_data;
      endcase
   end

endmodule

// File: rtl/data_mem_access_unit.sv
// ---------------------------------------------------------------------------
// data_mem_access_unit
// Load/store unit in front of data memory port b. Turns byte/half/word
// requests into word-only memory cycles, waits out the two-cycle registered
// read, and performs sub-word stores as read-modify-write.
// Ports:
//   clk, rst_n            clock (shared with memory port b), async active-low reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   resp_valid            one-cycle completion pulse
//   resp_rdata, resp_err  completion data / fault flag, held until next completion
//   mem_addr, mem_we, mem_wdata, mem_rdata   memory port b
// ---------------------------------------------------------------------------
module data_mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int ADDR_WIDTH = 14,
   parameter int DATA_WIDTH = 32
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   state_e                state_q, state_d;
   logic                  accept;
   logic                  req_fault;
   logic                  req_word_store;

   // Request fields captured at the accept edge.
   logic                  we_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic [1:0]            off_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   logic [DATA_WIDTH-1:0] load_data;
   logic [DATA_WIDTH-1:0] merged_word;

   // Address bits above the word index wrap around the memory.
   logic                  unused_addr_bits;
   assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

   assign accept         = req_valid && req_ready;
   assign req_fault      = access_fault(req_size, req_addr[1:0]);
   assign req_word_store = req_we && (req_size == SZ_WORD);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state and state-decoded outputs. mem_we comes straight from the
   // state, so a reset anywhere in the sequence can never leave a write behind.
   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      mem_we     = 1'b0;
      resp_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (accept) begin
               if (req_fault)           state_d = ST_RESP;
               else if (req_word_store) state_d = ST_WR;
               else                     state_d = ST_RD0;
            end
         end
         ST_RD0:  state_d = ST_RD1;
         ST_RD1:  state_d = ST_RD2;
         ST_RD2:  state_d = we_q ? ST_WR : ST_RESP;
         ST_WR: begin
            mem_we  = 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Request latches: only meaningful while busy, so no reset needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= req_we;
         size_q  <= req_size;
         uns_q   <= req_unsigned;
         off_q   <= req_addr[1:0];
         wdata_q <= req_wdata;
      end
   end

   mem_lane_align #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_lane_align (
      .rd_word     (mem_rdata),
      .offset      (off_q),
      .size        (size_q),
      .is_unsigned (uns_q),
      .new_data    (wdata_q),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   // Memory drive and response registers. mem_rdata is valid throughout RD2,
   // so it is steered through the aligner and captured on the RD2 edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr   <= '0;
         mem_wdata  <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (req_fault) begin
                     resp_rdata <= '0;
                     resp_err   <= 1'b1;
                  end else begin
                     mem_addr <= req_addr[ADDR_WIDTH+1:2];
                     if (req_word_store) mem_wdata <= req_wdata;
                  end
               end
            end
            ST_RD2: begin
               if (we_q) begin
                  mem_wdata <= merged_word;
               end else begin
                  resp_rdata <= load_data;
                  resp_err   <= 1'b0;
               end
            end
            ST_WR: begin
               resp_rdata <= '0;
               resp_err   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_data_mem_access_unit
// Table-driven bench with a response scoreboard and a behavioural model of
// data memory port b (registered read, two edges of latency).
// ---------------------------------------------------------------------------
module tb_data_mem_access_unit;

   localparam int ADDR_WIDTH = 14;
   localparam int DATA_WIDTH = 32;

   logic                  clk;
   logic                  rst_n;
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [1:0]            req_size;
   logic                  req_unsigned;
   logic [31:0]           req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_err;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_we;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   data_mem_access_unit #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- memory model ----------------
   logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
   logic [31:0] rd_p1;
   logic        pre_we;
   logic [13:0] pre_addr;
   logic [31:0] pre_data;

   always @(posedge clk) begin
      if (pre_we)      mem[pre_addr] <= pre_data;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
      rd_p1     <= mem[mem_addr];
      mem_rdata <= rd_p1;
   end

   // ---------------- bookkeeping ----------------
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;
   exp_t exp_q[$];

   // Scoreboard: every completion is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && resp_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got resp_valid=1 expected none at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            chk("resp_latency", cyc, e.due);
         end
      end
   end

   // Write-pulse observer.
   int          we_cnt = 0;
   int          we_cyc = 0;
   logic [31:0] we_addr, we_data;
   always @(negedge clk) begin
      if (mem_we) begin
         we_cnt  = we_cnt + 1;
         we_cyc  = cyc;
         we_addr = {18'd0, mem_addr};
         we_data = mem_wdata;
      end
   end

   int last_acc;   // cycle number of the accept edge; cycle acc+k is "cycle k"

   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] erd, input logic eerr, input int lat);
      exp_t e;
      bit   got;
      int   n;
      @(posedge clk); #1;
      n = 0;
      while (!req_ready && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL ready_timeout: got req_ready=0 expected 1");
      end
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd;
      @(posedge clk); #1;
      last_acc  = cyc - 1;
      req_valid = 1'b0;
      e.rdata = erd; e.err = eerr; e.due = last_acc + lat;
      exp_q.push_back(e);
      chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         @(negedge clk);
         if (resp_valid) got = 1'b1;
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL resp_timeout: got no resp_valid expected one for addr 0x%08h", addr);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
      chk({tag, "_resp_err"},   {31'd0, resp_err}, 32'd0);
      chk({tag, "_mem_addr"},   {18'd0, mem_addr}, 32'd0);
      chk({tag, "_mem_we"},     {31'd0, mem_we}, 32'd0);
      chk({tag, "_mem_wdata"},  mem_wdata, 32'd0);
      chk({tag, "_req_ready"},  {31'd0, req_ready}, 32'd1);
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] erd;
      logic        eerr;
      int          lat;
   } vec_t;

   vec_t vecs[11];
   int   we_before;

   initial begin
      // Word 0x10 holds 0x8899AABB (bytes BB,AA,99,88 at byte addresses 0x40..0x43).
      vecs[0]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0041, 32'h0, 32'h0000_00AA, 1'b0, 4};
      vecs[1]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0042, 32'h0, 32'hFFFF_8899, 1'b0, 4};
      vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0040, 32'h0, 32'hFFFF_FFBB, 1'b0, 4};
      vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0042, 32'h0, 32'h0000_8899, 1'b0, 4};
      vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h8899_AABB, 1'b0, 4};
      vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0043, 32'h0, 32'hFFFF_FF88, 1'b0, 4};
      vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0042, 32'h0, 32'h0000_0000, 1'b1, 1};
      vecs[7]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0001, 32'h1234, 32'h0000_0000, 1'b1, 1};
      vecs[8]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0000, 1'b1, 1};
      vecs[9]  = '{1'b0, 2'b00, 1'b1, 32'h0001_0041, 32'h0, 32'h0000_00AA, 1'b0, 4};
      vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_0040, 32'h0, 32'hFFFF_AABB, 1'b0, 4};

      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      pre_we = 1'b1; pre_addr = 14'h10; pre_data = 32'h8899_AABB;
      @(posedge clk); #1;
      chk_reset_outputs("reset");
      @(posedge clk); #1;
      pre_we = 1'b0;
      rst_n  = 1'b1;

      // Table-driven loads and faults; faults must never touch memory.
      we_before = we_cnt;
      for (int i = 0; i < 11; i++)
         issue(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
               vecs[i].erd, vecs[i].eerr, vecs[i].lat);
      chk("fault_no_write", we_cnt, we_before);

      // Byte store: read-modify-write, single write pulse in cycle 4.
      we_before = we_cnt;
      issue(1'b1, 2'b00, 1'b0, 32'h0000_0043, 32'hFFFF_FF55, 32'h0, 1'b0, 5);
      chk("sb_we_count", we_cnt, we_before + 1);
      chk("sb_we_cycle", we_cyc, last_acc + 4);
      chk("sb_we_addr",  we_addr, 32'h10);
      chk("sb_we_data",  we_data, 32'h5599_AABB);
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h5599_AABB, 1'b0, 4);

      // Half store into the upper half.
      we_before = we_cnt;
      issue(1'b1, 2'b01, 1'b0, 32'h0000_0042, 32'hABCD_1234, 32'h0, 1'b0, 5);
      chk("sh_we_count", we_cnt, we_before + 1);
      chk("sh_we_data",  we_data, 32'h1234_AABB);
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_AABB, 1'b0, 4);

      // Word store: direct write in cycle 1, completion in cycle 2.
      we_before = we_cnt;
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0080, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
      chk("sw_ready_in_resp", {31'd0, req_ready}, 32'd0);
      chk("sw_we_count", we_cnt, we_before + 1);
      chk("sw_we_cycle", we_cyc, last_acc + 1);
      chk("sw_we_addr",  we_addr, 32'h20);
      chk("sw_we_data",  we_data, 32'hDEAD_BEEF);
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0, 32'hDEAD_BEEF, 1'b0, 4);

      // Byte store aborted by reset during RD1.
      we_before = we_cnt;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h0000_0040; req_wdata = 32'h77;
      @(posedge clk); #1;
      last_acc  = cyc - 1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("abort");
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("abort_no_write", we_cnt, we_before);
      chk("abort_mem_kept", mem[14'h10], 32'h1234_AABB);
      issue(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h1234_AABB, 1'b0, 4);

      repeat (2) @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no completion expected finish before 200000");
      $fatal(1);
   end

endmodule
